// File: rtl/fifo_pkg.sv
// Shared types and sizes for the command FIFO.
// Width and depth defaults used by fifo and its bench.
package fifo_pkg;

  localparam int FIFO_WIDTH = 5;
  localparam int FIFO_DEPTH = 8;

  typedef logic [FIFO_WIDTH-1:0] cmd_t;
  typedef logic [$clog2(FIFO_DEPTH):0] fifo_count_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port,
// registered read port with async clear and hold.
module fifo_mem #(
  parameter int WIDTH = 5,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];

  // store an accepted write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // output register updates only on an accepted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo.sv
// Single-clock command FIFO with tail delete.
// Pointer, count and flag control around fifo_mem.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic             del,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic del_ok;
  logic wr_ok;
  logic rd_ok;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // delete wins; write/read judged on pre-edge count
  assign del_ok = del & ~empty;
  assign wr_ok  = ~del & we & ~full;
  assign rd_ok  = ~del & re & ~empty;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (del_ok) begin
      wr_ptr <= wr_ptr - AW'(1);
      count  <= count - CW'(1);
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: vector table, directed corners,
// and random traffic against a queue model.
module tb_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst;
  logic we;
  logic re;
  logic del;
  cmd_t data_in;
  cmd_t data_out;
  logic empty;
  logic full;

  int nchk = 0;
  int nerr = 0;

  cmd_t q[$];
  cmd_t m_do;

  typedef struct {
    logic we;
    logic re;
    logic del;
    cmd_t din;
    cmd_t exp_do;
    logic exp_e;
    logic exp_f;
  } vec_t;

  vec_t tv[16];

  fifo dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .re       (re),
    .del      (del),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_step(
    input logic w,
    input logic r,
    input logic d,
    input cmd_t din
  );
    bit do_rd;
    bit do_wr;
    if (d) begin
      if (q.size() > 0) void'(q.pop_back());
    end else begin
      do_rd = r && (q.size() > 0);
      do_wr = w && (q.size() < DEPTH);
      if (do_rd) m_do = q.pop_front();
      if (do_wr) q.push_back(din);
    end
  endtask

  task automatic model_chk();
    chk("m_dout", 32'(data_out), 32'(m_do));
    chk("m_empty", 32'(empty),
        32'(q.size() == 0));
    chk("m_full", 32'(full),
        32'(q.size() == DEPTH));
  endtask

  task automatic cycle(
    input logic w,
    input logic r,
    input logic d,
    input cmd_t din
  );
    we = w;
    re = r;
    del = d;
    data_in = din;
    @(posedge clk);
    model_step(w, r, d, din);
    @(negedge clk);
    model_chk();
    we = 1'b0;
    re = 1'b0;
    del = 1'b0;
  endtask

  task automatic wr(input cmd_t d);
    cycle(1'b1, 1'b0, 1'b0, d);
  endtask

  task automatic rd_exp(input cmd_t e);
    cycle(1'b0, 1'b1, 1'b0, 5'd0);
    chk("rd_val", 32'(data_out), 32'(e));
  endtask

  initial begin
    cmd_t exp_seq[10];
    rst = 1'b0;
    we = 1'b0;
    re = 1'b0;
    del = 1'b0;
    data_in = '0;
    m_do = '0;

    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    rst = 1'b1;

    // idle, write/delete, delete corners
    tv[0]  = '{0, 0, 0, 7, 0, 1, 0};
    tv[1]  = '{0, 0, 0, 4, 0, 1, 0};
    tv[2]  = '{0, 0, 0, 3, 0, 1, 0};
    tv[3]  = '{1, 0, 0, 7, 0, 0, 0};
    tv[4]  = '{1, 0, 0, 4, 0, 0, 0};
    tv[5]  = '{1, 0, 0, 2, 0, 0, 0};
    tv[6]  = '{0, 0, 1, 0, 0, 0, 0};
    tv[7]  = '{1, 0, 0, 2, 0, 0, 0};
    tv[8]  = '{0, 1, 0, 0, 7, 0, 0};
    tv[9]  = '{0, 1, 0, 0, 4, 0, 0};
    tv[10] = '{0, 1, 0, 0, 2, 1, 0};
    tv[11] = '{0, 1, 0, 0, 2, 1, 0};
    tv[12] = '{0, 0, 1, 0, 2, 1, 0};
    tv[13] = '{1, 0, 0, 9, 2, 0, 0};
    tv[14] = '{1, 0, 1, 5, 2, 1, 0};
    tv[15] = '{0, 1, 0, 0, 2, 1, 0};

    for (int i = 0; i < 16; i++) begin
      cycle(tv[i].we, tv[i].re,
            tv[i].del, tv[i].din);
      chk("tv_dout", 32'(data_out),
          32'(tv[i].exp_do));
      chk("tv_empty", 32'(empty),
          32'(tv[i].exp_e));
      chk("tv_full", 32'(full),
          32'(tv[i].exp_f));
    end

    // async reset between edges
    wr(5'd1);
    wr(5'd2);
    wr(5'd3);
    rd_exp(5'd1);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    m_do = '0;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_dout", 32'(data_out), 32'd0);
    repeat (4) @(negedge clk);
    chk("arst_hold", 32'(empty), 32'd1);
    rst = 1'b1;
    rd_exp(5'd0);
    chk("arst_after", 32'(empty), 32'd1);

    // fill seven then drain with latency 1
    for (int i = 0; i < 7; i++) wr(5'(i));
    chk("fill7_full", 32'(full), 32'd0);
    for (int i = 0; i < 20; i++)
      rd_exp(5'((i < 7) ? i : 6));
    chk("drain_empty", 32'(empty), 32'd1);

    // overflow and pointer wrap
    for (int i = 0; i < 8; i++)
      wr(5'(10 + i));
    chk("ovf_full", 32'(full), 32'd1);
    wr(5'd31);
    chk("ovf_drop", 32'(full), 32'd1);
    rd_exp(5'd10);
    rd_exp(5'd11);
    wr(5'd20);
    wr(5'd21);
    chk("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 6; i++)
      exp_seq[i] = 5'(12 + i);
    exp_seq[6] = 5'd20;
    exp_seq[7] = 5'd21;
    for (int i = 0; i < 8; i++)
      rd_exp(exp_seq[i]);
    chk("wrap_empty", 32'(empty), 32'd1);

    // full: read proceeds, write dropped
    for (int i = 0; i < 8; i++)
      wr(5'(i + 1));
    cycle(1'b1, 1'b1, 1'b0, 5'd30);
    chk("full_rw_do", 32'(data_out), 32'd1);
    chk("full_rw_f", 32'(full), 32'd0);
    for (int i = 0; i < 7; i++)
      rd_exp(5'(i + 2));
    chk("full_rw_e", 32'(empty), 32'd1);

    // empty: write proceeds, no fall-through
    cycle(1'b1, 1'b1, 1'b0, 5'd19);
    chk("empty_rw_do", 32'(data_out), 32'd8);
    rd_exp(5'd19);

    // simultaneous read/write with 3 stored
    wr(5'd1);
    wr(5'd2);
    wr(5'd3);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 5'(4 + i));
      chk("rw_do", 32'(data_out), 32'(1 + i));
      chk("rw_e", 32'(empty), 32'd0);
    end
    rd_exp(5'd5);
    rd_exp(5'd6);
    rd_exp(5'd7);
    chk("rw_end_e", 32'(empty), 32'd1);

    // random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0),
            5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
